// File: rtl/arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DATA_WD_DEF = 4;

    // One spare bit over the minimum so the counter never wraps at DATA_WD-1.
    function automatic int cnt_wd(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/fs_cell.sv
// Purpose: one-bit full subtractor, diff = a - b - bin.
// Latency: combinational.
// Backpressure: none.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial A - B - bin, LSB first, through one fs_cell and a borrow flop.
// Latency: o_valid high DATA_WD edges after accept; issue interval DATA_WD+2 cycles.
// Backpressure: result held in DONE until i_ready; o_ready only in IDLE.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int DATA_WD = DATA_WD_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [DATA_WD-1:0] i_a,
    input  logic [DATA_WD-1:0] i_b,
    input  logic               i_bin,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_WD-1:0] o_diff,
    output logic               o_borrow,
    output logic               o_ovf
);

    localparam int CNT_WD = cnt_wd(DATA_WD);
    localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(DATA_WD - 1);

    state_t              state_q, state_d;
    logic [DATA_WD-1:0]  a_sr, b_sr, res_sr, res_nxt;
    logic [CNT_WD-1:0]   cnt_q;
    logic                bw_q;
    logic                d_bit, bw_nxt;
    logic                last_step;

    fs_cell u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bw_q),
        .diff (d_bit),
        .bout (bw_nxt)
    );

    // Result bits enter at the MSB so the LSB lands at bit 0 after DATA_WD steps.
    assign res_nxt   = (res_sr >> 1) | (DATA_WD'(d_bit) << (DATA_WD - 1));
    assign last_step = (cnt_q == LAST_CNT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs only update on the final step, so they hold through IDLE and SHIFT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bw_q     <= 1'b0;
            cnt_q    <= '0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_sr  <= i_a;
                        b_sr  <= i_b;
                        bw_q  <= i_bin;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    bw_q   <= bw_nxt;
                    res_sr <= res_nxt;
                    cnt_q  <= cnt_q + CNT_WD'(1);
                    if (last_step) begin
                        o_diff   <= res_nxt;
                        o_borrow <= bw_nxt;
                        o_ovf    <= bw_q ^ bw_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at DATA_WD=4: directed vectors, backpressure, mid-op reset, exhaustive sweep.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a, i_b;
    logic         i_bin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_ovf;

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.DATA_WD(W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_bin    (i_bin),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_ovf    (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input int a, input int b, input int bin);
        int r, sa, sb, sr;
        logic [W-1:0] d;
        logic bo, ov;
        r  = a - b - bin;
        d  = W'(r);
        bo = (a < b + bin);
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        sr = sa - sb - bin;
        ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
        return {d, bo, ov};
    endfunction

    // Present operands; returns after the accept edge (sampled 1 time unit later).
    task automatic issue(input int a, input int b, input int bin);
        int n;
        @(negedge i_clk);
        i_a = W'(a); i_b = W'(b); i_bin = bin[0]; i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until o_valid is seen; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge i_clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_a = '0; i_b = '0; i_bin = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        n_cmp++;
        if ({o_ready, o_valid, o_diff, o_borrow, o_ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b diff=%h bo=%b ov=%b expected rdy=1 vld=0 diff=0 bo=0 ov=0",
                     o_ready, o_valid, o_diff, o_borrow, o_ovf);
        end
    endtask

    task automatic test_directed;
        int va[4]   = '{6, 3, 7, 0};
        int vb[4]   = '{3, 5, 8, 0};
        int vbin[4] = '{0, 0, 0, 1};
        logic [5:0] vexp[4] = '{{4'h3, 1'b0, 1'b0}, {4'hE, 1'b1, 1'b0},
                                {4'hF, 1'b1, 1'b1}, {4'hF, 1'b1, 1'b0}};
        int n;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(va[i], vb[i], vbin[i]);
            wait_valid(n);
            n_cmp++;
            if (n !== W || o_valid !== 1'b1) begin
                n_err++;
                $display("FAIL directed_latency[%0d]: got %0d edges (vld=%b) expected %0d", i, n, o_valid, W);
            end
            n_cmp++;
            if ({o_diff, o_borrow, o_ovf} !== vexp[i]) begin
                n_err++;
                $display("FAIL directed_result[%0d]: got diff=%h bo=%b ov=%b expected diff=%h bo=%b ov=%b",
                         i, o_diff, o_borrow, o_ovf, vexp[i][5:2], vexp[i][1], vexp[i][0]);
            end
            n_cmp++;
            if (model(va[i], vb[i], vbin[i]) !== vexp[i]) begin
                n_err++;
                $display("FAIL directed_model[%0d]: got %h expected %h", i, model(va[i], vb[i], vbin[i]), vexp[i]);
            end
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int n;
        i_ready = 1'b0;
        issue(3, 5, 0);
        wait_valid(n);
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_a = W'($urandom); i_b = W'($urandom); i_bin = 1'($urandom);
            @(posedge i_clk);
            #1;
            n_cmp++;
            if ({o_valid, o_ready, o_diff, o_borrow, o_ovf} !== {1'b1, 1'b0, 4'hE, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: got vld=%b rdy=%b diff=%h bo=%b ov=%b expected vld=1 rdy=0 diff=e bo=1 ov=0",
                         c, o_valid, o_ready, o_diff, o_borrow, o_ovf);
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_valid, o_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_release: got vld=%b rdy=%b expected vld=0 rdy=1", o_valid, o_ready);
        end
        repeat (3) @(posedge i_clk);
        #1;
        n_cmp++;
        if ({o_valid, o_ready, o_diff} !== {1'b0, 1'b1, 4'hE}) begin
            n_err++;
            $display("FAIL hold_not_consumed: got vld=%b rdy=%b diff=%h expected vld=0 rdy=1 diff=e",
                     o_valid, o_ready, o_diff);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit spurious;
        i_ready = 1'b1;
        issue(12, 3, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        n_cmp++;
        if ({o_ready, o_valid, o_diff, o_borrow, o_ovf} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_outputs: got rdy=%b vld=%b diff=%h bo=%b ov=%b expected rdy=1 vld=0 diff=0 bo=0 ov=0",
                     o_ready, o_valid, o_diff, o_borrow, o_ovf);
        end
        spurious = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_valid: got spurious o_valid=%b expected 0", spurious);
        end
        issue(9, 9, 0);
        wait_valid(n);
        n_cmp++;
        if ({o_valid, o_diff, o_borrow, o_ovf} !== {1'b1, 4'h0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midreset_rerun: got vld=%b diff=%h bo=%b ov=%b expected vld=1 diff=0 bo=0 ov=0",
                     o_valid, o_diff, o_borrow, o_ovf);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_exhaustive;
        int n, stall;
        logic [W+1:0] exp;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    i_ready = 1'($urandom);
                    issue(a, b, bin);
                    wait_valid(n);
                    i_ready = 1'b0;
                    stall = $urandom_range(0, 3);
                    repeat (stall) begin
                        @(posedge i_clk);
                        #1;
                    end
                    exp = model(a, b, bin);
                    n_cmp++;
                    if ({o_valid, o_diff, o_borrow, o_ovf} !== {1'b1, exp} || n !== W) begin
                        n_err++;
                        $display("FAIL exhaustive a=%0d b=%0d bin=%0d: got vld=%b diff=%h bo=%b ov=%b lat=%0d expected vld=1 diff=%h bo=%b ov=%b lat=%0d",
                                 a, b, bin, o_valid, o_diff, o_borrow, o_ovf, n, exp[W+1:2], exp[1], exp[0], W);
                    end
                    @(negedge i_clk);
                    i_ready = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_ready = 1'b0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_exhaustive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
